// File: rtl/bp_pkg.sv
// Shared branch-prediction package.
// Holds the 2-bit prediction-state encodings (also used by branch_unit),
// the BTB init/run state type, and PC -> index/tag extraction helpers.
// The helpers work on a wide PC and take the index width as an argument,
// so one definition serves any ENTRIES/PC_W combination. Callers cast
// the result down to their own index or tag width.
package bp_pkg;

  // Prediction-state encodings. Bit 1 set means "predict taken".
  localparam logic [1:0] CTRL_SNT = 2'b00;
  localparam logic [1:0] CTRL_WNT = 2'b01;
  localparam logic [1:0] CTRL_WT  = 2'b10;
  localparam logic [1:0] CTRL_ST  = 2'b11;
  localparam int         CTRL_TAKEN_BIT = 1;

  // Widest PC the helpers accept.
  localparam int PC_MAX_W = 64;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} btb_state_e;

  // index = pc[idx_w+1:2]
  function automatic logic [PC_MAX_W-1:0] bp_index(input logic [PC_MAX_W-1:0] pc,
                                                   input int idx_w);
    logic [PC_MAX_W-1:0] mask;
    mask = (PC_MAX_W'(1) << idx_w) - PC_MAX_W'(1);
    return (pc >> 2) & mask;
  endfunction

  // tag = pc[PC_W-1:idx_w+2]; the caller truncates to its tag width
  function automatic logic [PC_MAX_W-1:0] bp_tag(input logic [PC_MAX_W-1:0] pc,
                                                 input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/btb_mem.sv
// BTB entry array: one asynchronous read port, one synchronous write port.
// A write to the same index as the read in the same cycle is forwarded to
// the read data (write-first), so a lookup sees an update in its own cycle.
// Ports:
//   clk_i                         clock
//   we_i, widx_i                  write strobe / entry index
//   wvalid_i, wtag_i, wtarget_i,
//   wctrl_i                       write data
//   ridx_i                        read index
//   rvalid_o, rtag_o, rtarget_o,
//   rctrl_o                       read data (bypassed)
module btb_mem #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26,
  parameter int PC_W    = 32
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic             wvalid_i,
  input  logic [TAG_W-1:0] wtag_i,
  input  logic [PC_W-1:0]  wtarget_i,
  input  logic [1:0]       wctrl_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic             rvalid_o,
  output logic [TAG_W-1:0] rtag_o,
  output logic [PC_W-1:0]  rtarget_o,
  output logic [1:0]       rctrl_o
);

  // No reset here: the top-level init sweep clears valid/ctrl.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [1:0]       ctrl_q   [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      valid_q[widx_i]  <= wvalid_i;
      tag_q[widx_i]    <= wtag_i;
      target_q[widx_i] <= wtarget_i;
      ctrl_q[widx_i]   <= wctrl_i;
    end
  end

  logic byp;
  assign byp = we_i && (widx_i == ridx_i);

  always_comb begin
    rvalid_o  = valid_q[ridx_i];
    rtag_o    = tag_q[ridx_i];
    rtarget_o = target_q[ridx_i];
    rctrl_o   = ctrl_q[ridx_i];
    if (byp) begin
      rvalid_o  = wvalid_i;
      rtag_o    = wtag_i;
      rtarget_o = wtarget_i;
      rctrl_o   = wctrl_i;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage.
// A lookup presented in cycle N produces registered hit/taken/target/ctrl
// after edge N+1. Write-backs from branch_unit allocate unconditionally.
// After reset, valid bits are cleared one entry per cycle (INIT); lookups
// miss and updates are dropped until the sweep finishes and Ready rises.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   LookupEn, LookupPC           lookup request
//   PcMatchValid, JumpTaken,
//   PredTarget, CtrlPred         registered lookup result
//   UpdEn, UpdPC, UpdTarget,
//   UpdCtrl                      write-back from branch_unit
//   Ready                        init sweep complete
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            LookupEn,
  input  logic [PC_W-1:0] LookupPC,
  output logic            PcMatchValid,
  output logic            JumpTaken,
  output logic [PC_W-1:0] PredTarget,
  output logic [1:0]      CtrlPred,
  input  logic            UpdEn,
  input  logic [PC_W-1:0] UpdPC,
  input  logic [PC_W-1:0] UpdTarget,
  input  logic [1:0]      UpdCtrl,
  output logic            Ready
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  btb_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             clr;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep: clear entry [cnt] each INIT cycle; counter wraps to 0 on exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    case (state_q)
      INIT: begin
        clr   = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Address split
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  assign lk_idx = IDX_W'(bp_index(PC_MAX_W'(LookupPC), IDX_W));
  assign lk_tag = TAG_W'(bp_tag(PC_MAX_W'(LookupPC), IDX_W));
  assign up_idx = IDX_W'(bp_index(PC_MAX_W'(UpdPC), IDX_W));
  assign up_tag = TAG_W'(bp_tag(PC_MAX_W'(UpdPC), IDX_W));

  // Single write port shared by the sweep (INIT) and write-backs (RUN).
  logic             upd_ok;
  logic             m_we, m_wvalid;
  logic [IDX_W-1:0] m_widx;
  logic [TAG_W-1:0] m_wtag;
  logic [PC_W-1:0]  m_wtarget;
  logic [1:0]       m_wctrl;

  assign upd_ok    = UpdEn && (state_q == RUN);
  assign m_we      = clr || upd_ok;
  assign m_widx    = clr ? cnt_q : up_idx;
  assign m_wvalid  = !clr;
  assign m_wtag    = clr ? '0 : up_tag;
  assign m_wtarget = clr ? '0 : UpdTarget;
  assign m_wctrl   = clr ? CTRL_SNT : UpdCtrl;

  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [PC_W-1:0]  r_target;
  logic [1:0]       r_ctrl;

  btb_mem #(
    .ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)
  ) u_mem (
    .clk_i     (clk),
    .we_i      (m_we),
    .widx_i    (m_widx),
    .wvalid_i  (m_wvalid),
    .wtag_i    (m_wtag),
    .wtarget_i (m_wtarget),
    .wctrl_i   (m_wctrl),
    .ridx_i    (lk_idx),
    .rvalid_o  (r_valid),
    .rtag_o    (r_tag),
    .rtarget_o (r_target),
    .rctrl_o   (r_ctrl)
  );

  // Lookup result; tag compare uses bypassed data when an update aliases.
  logic            hit_d, taken_d, ready_d;
  logic [PC_W-1:0] target_d;
  logic [1:0]      ctrl_d;

  assign hit_d    = (state_q == RUN) && LookupEn && r_valid && (r_tag == lk_tag);
  assign taken_d  = hit_d && r_ctrl[CTRL_TAKEN_BIT];
  assign target_d = hit_d ? r_target : '0;
  assign ctrl_d   = hit_d ? r_ctrl : CTRL_SNT;
  assign ready_d  = (state_d == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      PcMatchValid <= 1'b0;
      JumpTaken    <= 1'b0;
      PredTarget   <= '0;
      CtrlPred     <= CTRL_SNT;
      Ready        <= 1'b0;
    end else begin
      PcMatchValid <= hit_d;
      JumpTaken    <= taken_d;
      PredTarget   <= target_d;
      CtrlPred     <= ctrl_d;
      Ready        <= ready_d;
    end
  end

endmodule
